// File: rtl/fadd_arbiter.sv
// Two-requester front end sharing one single-precision adder with fixed sampling latency.
// Optional macro FADD_ARBITER_RR_EN selects round-robin arbitration (default: req0 fixed priority).
module float_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] z,
    output logic [1:0]  overflow
);
    // overflow: 00 normal, 01 finite result rounded to infinity, 10 invalid (NaN)
    function automatic logic [33:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p, q;
        logic [9:0]  ep, eq, e, dd, lz, sh;
        logic [23:0] mp, mq;
        logic [4:0]  d;
        logic [55:0] wide;
        logic [26:0] al, m;
        logic [27:0] sum;
        logic [24:0] mant;
        logic        inc;
        int          pos;
        if (a[30:0] >= b[30:0]) begin p = a; q = b; end
        else begin p = b; q = a; end
        // p has the larger magnitude, so any Inf/NaN operand lands in p
        if (p[30:23] == 8'hFF) begin
            if (p[22:0] != 23'd0 || (q[30:0] == p[30:0] && q[31] != p[31]))
                return {2'b10, 32'h7FC00000};
            return {2'b00, p};
        end
        ep = (p[30:23] == 8'd0) ? 10'd1 : {2'b00, p[30:23]};
        eq = (q[30:23] == 8'd0) ? 10'd1 : {2'b00, q[30:23]};
        mp = {p[30:23] != 8'd0, p[22:0]};
        mq = {q[30:23] != 8'd0, q[22:0]};
        dd = ep - eq;
        d  = (dd > 10'd31) ? 5'd31 : dd[4:0];
        wide = {mq, 32'd0} >> d;
        al   = {wide[55:30], |wide[29:0]};
        if (p[31] == q[31]) sum = {1'b0, mp, 3'b000} + {1'b0, al};
        else                sum = {1'b0, mp, 3'b000} - {1'b0, al};
        if (sum == 28'd0)
            return {2'b00, p[31] & q[31], 31'd0};
        e = ep;
        if (sum[27]) begin
            m = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'd1;
        end else begin
            pos = 0;
            for (int i = 0; i < 27; i++)
                if (sum[i]) pos = i;
            lz = 10'(26 - pos);
            sh = (lz < e) ? lz : e - 10'd1;
            m  = sum[26:0] << sh;
            e  = e - sh;
        end
        inc  = m[2] & (m[1] | m[0] | m[3]);
        mant = {1'b0, m[26:3]} + {24'd0, inc};
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 10'd1;
        end
        if (e >= 10'd255)
            return {2'b01, p[31], 8'hFF, 23'd0};
        return {2'b00, p[31], (mant[23] ? e[7:0] : 8'h00), mant[22:0]};
    endfunction

    // One register stage; the result is masked while the restart pin is low.
    logic [33:0] res_q;
    always_ff @(posedge clk)
        res_q <= fp_add(x, y);

    assign z        = rst ? res_q[31:0]  : 32'd0;
    assign overflow = rst ? res_q[33:32] : 2'b00;
endmodule

module fadd_arbiter #(
    parameter int unsigned LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_z,
    output logic [1:0]  rsp_ovf,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] op_x, op_y;
    logic        op_id;
    logic        grant0, grant1;
    logic        add_rst_n;
    logic [31:0] add_z;
    logic [1:0]  add_ovf;

`ifdef FADD_ARBITER_RR_EN
    logic ptr;  // 1: req1 favored on a tie
    assign grant1 = req1_valid && (!req0_valid || ptr);
`else
    assign grant1 = req1_valid && !req0_valid;
`endif
    assign grant0 = req0_valid && !grant1;

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign add_rst_n  = !rst && (state != START);

    float_adder u_add (
        .clk      (clk),
        .rst      (add_rst_n),
        .x        (op_x),
        .y        (op_y),
        .z        (add_z),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            op_x      <= 32'd0;
            op_y      <= 32'd0;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_z     <= 32'd0;
            rsp_ovf   <= 2'b00;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
`ifdef FADD_ARBITER_RR_EN
            ptr       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (grant0 || grant1) begin
                    op_x  <= grant1 ? req1_x : req0_x;
                    op_y  <= grant1 ? req1_y : req0_y;
                    op_id <= grant1;
                    busy  <= 1'b1;
                    state <= START;
`ifdef FADD_ARBITER_RR_EN
                    ptr   <= grant0;
`endif
                end
                START: begin
                    cnt   <= 8'(LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: if (cnt == 8'd0) begin
                    rsp_z     <= add_z;
                    rsp_ovf   <= add_ovf;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt - 8'd1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
